// File: rtl/udma_ethernet_cfg_master.sv
// Initiator for the uDMA ethernet cfg bus: single write / read / poll-until-match
// commands in, one cfg transaction at a time out, read data and status back on a
// response channel.
module udma_ethernet_cfg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned MAX_POLLS      = 256
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rwn_i,
    input  logic        cmd_poll_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [31:0] cmd_mask_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,

    output logic        cfg_valid_o,
    output logic        cfg_rwn_o,
    output logic [4:0]  cfg_addr_o,
    output logic [31:0] cfg_data_o,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_ready_i
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned POLL_W   = $clog2(MAX_POLLS + 1);
    localparam int unsigned GAP_W    = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_nxt;

    logic                lat_rwn_q,   lat_rwn_nxt;
    logic                lat_poll_q,  lat_poll_nxt;
    logic [4:0]          lat_addr_q,  lat_addr_nxt;
    logic [31:0]         lat_wdata_q, lat_wdata_nxt;
    logic [31:0]         lat_mask_q,  lat_mask_nxt;

    logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_nxt;
    logic [POLL_W-1:0]   poll_cnt_q,  poll_cnt_nxt;
    logic [GAP_W-1:0]    gap_cnt_q,   gap_cnt_nxt;

    logic                reissue_nxt;
    logic                poll_match;

    logic                cmd_ready_nxt;
    logic                rsp_valid_nxt;
    logic [31:0]         rsp_rdata_nxt;
    logic                rsp_err_nxt;
    logic                cfg_valid_nxt;
    logic                cfg_rwn_nxt;
    logic [4:0]          cfg_addr_nxt;
    logic [31:0]         cfg_data_nxt;

    // Poll termination: masked bits of the returned word equal the masked compare value
    assign poll_match = ((cfg_data_i ^ lat_wdata_q) & lat_mask_q) == 32'd0;

    // State, latched command, counters and all registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            lat_rwn_q   <= 1'b0;
            lat_poll_q  <= 1'b0;
            lat_addr_q  <= 5'd0;
            lat_wdata_q <= 32'd0;
            lat_mask_q  <= 32'd0;
            wait_cnt_q  <= '0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
            cfg_valid_o <= 1'b0;
            cfg_rwn_o   <= 1'b0;
            cfg_addr_o  <= 5'd0;
            cfg_data_o  <= 32'd0;
        end else begin
            state_q     <= state_nxt;
            lat_rwn_q   <= lat_rwn_nxt;
            lat_poll_q  <= lat_poll_nxt;
            lat_addr_q  <= lat_addr_nxt;
            lat_wdata_q <= lat_wdata_nxt;
            lat_mask_q  <= lat_mask_nxt;
            wait_cnt_q  <= wait_cnt_nxt;
            poll_cnt_q  <= poll_cnt_nxt;
            gap_cnt_q   <= gap_cnt_nxt;
            cmd_ready_o <= cmd_ready_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            rsp_err_o   <= rsp_err_nxt;
            cfg_valid_o <= cfg_valid_nxt;
            cfg_rwn_o   <= cfg_rwn_nxt;
            cfg_addr_o  <= cfg_addr_nxt;
            cfg_data_o  <= cfg_data_nxt;
        end
    end

    // Next-state, counter and next-output decode
    always_comb begin
        state_nxt     = state_q;
        lat_rwn_nxt   = lat_rwn_q;
        lat_poll_nxt  = lat_poll_q;
        lat_addr_nxt  = lat_addr_q;
        lat_wdata_nxt = lat_wdata_q;
        lat_mask_nxt  = lat_mask_q;
        wait_cnt_nxt  = wait_cnt_q;
        poll_cnt_nxt  = poll_cnt_q;
        gap_cnt_nxt   = gap_cnt_q;
        rsp_rdata_nxt = rsp_rdata_o;
        rsp_err_nxt   = rsp_err_o;
        reissue_nxt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    lat_rwn_nxt   = cmd_rwn_i;
                    // A poll flag on a write is meaningless; treat it as a plain write
                    lat_poll_nxt  = cmd_poll_i & cmd_rwn_i;
                    lat_addr_nxt  = cmd_addr_i;
                    lat_wdata_nxt = cmd_wdata_i;
                    lat_mask_nxt  = cmd_mask_i;
                    poll_cnt_nxt  = '0;
                    wait_cnt_nxt  = '0;
                    rsp_rdata_nxt = 32'd0;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = ISSUE;
                end
            end

            ISSUE: begin
                // cfg_valid_o low here only in the one-cycle separator of a zero-gap poll
                if (cfg_valid_o) begin
                    if (cfg_ready_i) begin
                        if (!lat_rwn_q) begin
                            rsp_rdata_nxt = 32'd0;
                            rsp_err_nxt   = 1'b0;
                            state_nxt     = RESP;
                        end else if (!lat_poll_q) begin
                            rsp_rdata_nxt = cfg_data_i;
                            rsp_err_nxt   = 1'b0;
                            state_nxt     = RESP;
                        end else begin
                            rsp_rdata_nxt = cfg_data_i;
                            poll_cnt_nxt  = poll_cnt_q + POLL_W'(1);
                            if (poll_match) begin
                                rsp_err_nxt = 1'b0;
                                state_nxt   = RESP;
                            end else if (poll_cnt_nxt == POLL_W'(MAX_POLLS)) begin
                                rsp_err_nxt = 1'b1;
                                state_nxt   = RESP;
                            end else if (POLL_GAP == 0) begin
                                reissue_nxt  = 1'b1;
                                wait_cnt_nxt = '0;
                            end else begin
                                gap_cnt_nxt = '0;
                                state_nxt   = GAP;
                            end
                        end
                    end else begin
                        wait_cnt_nxt = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_nxt == WAIT_W'(TIMEOUT_CYCLES)) begin
                            rsp_rdata_nxt = 32'd0;
                            rsp_err_nxt   = 1'b1;
                            state_nxt     = RESP;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = ISSUE;
                end else begin
                    gap_cnt_nxt = gap_cnt_q + GAP_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are glitch-free registers
        cmd_ready_nxt = (state_nxt == IDLE);
        rsp_valid_nxt = (state_nxt == RESP);
        cfg_valid_nxt = (state_nxt == ISSUE) && !reissue_nxt;
        cfg_rwn_nxt   = (state_nxt == ISSUE) ? lat_rwn_nxt : 1'b0;
        cfg_addr_nxt  = (state_nxt == ISSUE) ? lat_addr_nxt : 5'd0;
        cfg_data_nxt  = ((state_nxt == ISSUE) && !lat_rwn_nxt) ? lat_wdata_nxt : 32'd0;
    end

endmodule

// File: tb/tb_udma_ethernet_cfg_master.sv
// Directed bench for udma_ethernet_cfg_master: a table of single commands against
// a scripted cfg slave, plus hand sequences for response backpressure, reset in
// the middle of a transaction and poll exhaustion with a zero poll gap.
module tb_udma_ethernet_cfg_master;

    logic        clk;
    logic        rstn;

    // Default-parameter DUT
    logic        cmd_valid, cmd_ready, cmd_rwn, cmd_poll;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata, cmd_mask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cfg_valid, cfg_rwn, cfg_ready;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data_out, cfg_data_in;

    // Second DUT: MAX_POLLS=3, POLL_GAP=0, slave always ready returning 0xA5
    logic        cmd2_valid, cmd2_ready, cmd2_rwn, cmd2_poll;
    logic [4:0]  cmd2_addr;
    logic [31:0] cmd2_wdata, cmd2_mask;
    logic        rsp2_valid, rsp2_ready, rsp2_err;
    logic [31:0] rsp2_rdata;
    logic        cfg2_valid, cfg2_rwn, cfg2_ready;
    logic [4:0]  cfg2_addr;
    logic [31:0] cfg2_data_out, cfg2_data_in;

    assign cfg2_ready   = 1'b1;
    assign cfg2_data_in = 32'h0000_00A5;

    udma_ethernet_cfg_master dut (
        .clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rwn_i(cmd_rwn),
        .cmd_poll_i(cmd_poll), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .cfg_valid_o(cfg_valid), .cfg_rwn_o(cfg_rwn), .cfg_addr_o(cfg_addr),
        .cfg_data_o(cfg_data_out), .cfg_data_i(cfg_data_in), .cfg_ready_i(cfg_ready)
    );

    udma_ethernet_cfg_master #(.TIMEOUT_CYCLES(16), .POLL_GAP(0), .MAX_POLLS(3)) dut2 (
        .clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd2_valid), .cmd_ready_o(cmd2_ready), .cmd_rwn_i(cmd2_rwn),
        .cmd_poll_i(cmd2_poll), .cmd_addr_i(cmd2_addr), .cmd_wdata_i(cmd2_wdata),
        .cmd_mask_i(cmd2_mask),
        .rsp_valid_o(rsp2_valid), .rsp_ready_i(rsp2_ready), .rsp_rdata_o(rsp2_rdata),
        .rsp_err_o(rsp2_err),
        .cfg_valid_o(cfg2_valid), .cfg_rwn_o(cfg2_rwn), .cfg_addr_o(cfg2_addr),
        .cfg_data_o(cfg2_data_out), .cfg_data_i(cfg2_data_in), .cfg_ready_i(cfg2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scripted slave for the default DUT: ready after slv_delay valid cycles (or never)
    int unsigned slv_delay = 0;
    bit          slv_never = 1'b0;
    int unsigned slv_wait  = 0;
    logic [31:0] hi_val = 32'd0, lo_val = 32'd0;
    int unsigned hi_reads = 0;
    int unsigned read_cnt = 0;

    always @(negedge clk) begin
        if (cfg_valid) begin
            cfg_ready = !slv_never && (slv_wait >= slv_delay);
            slv_wait++;
        end else begin
            cfg_ready = 1'b0;
            slv_wait  = 0;
        end
        cfg_data_in = (read_cnt < hi_reads) ? hi_val : lo_val;
    end

    // Bus monitor: cycle count, handshake log, valid-cycle count, stability while valid
    int          cyc = 0;
    int          nlog = 0, n2 = 0, vcnt = 0, stab_bad = 0, acc_cnt = 0;
    int          log_cyc[16];
    logic        log_rwn[16];
    logic [4:0]  log_addr[16];
    logic [31:0] log_data[16];
    int          log2_cyc[16];
    logic        prev_v = 1'b0, prev_rwn = 1'b0;
    logic [4:0]  prev_addr = 5'd0;
    logic [31:0] prev_data = 32'd0;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (cfg_valid) begin
            vcnt++;
            if (prev_v && (cfg_addr !== prev_addr || cfg_data_out !== prev_data || cfg_rwn !== prev_rwn))
                stab_bad++;
        end
        if (cfg_valid && cfg_ready) begin
            if (nlog < 16) begin
                log_cyc[nlog]  = cyc;
                log_rwn[nlog]  = cfg_rwn;
                log_addr[nlog] = cfg_addr;
                log_data[nlog] = cfg_data_out;
            end
            nlog++;
            read_cnt++;
        end
        if (cfg2_valid && cfg2_ready) begin
            if (n2 < 16) log2_cyc[n2] = cyc;
            n2++;
        end
        prev_v    = cfg_valid && !cfg_ready;
        prev_rwn  = cfg_rwn;
        prev_addr = cfg_addr;
        prev_data = cfg_data_out;
        cyc++;
    end

    typedef struct {
        logic        rwn;
        logic        poll;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        int          delay;
        bit          never;
        logic [31:0] hval;
        int          hreads;
        logic [31:0] lval;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_reads;
        int          exp_lat;
        int          exp_vcyc;
        int          exp_gap;
    } vec_t;

    vec_t vecs[7];

    // Issue one command on the default DUT and check the whole transaction
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        slv_delay = v.delay;
        slv_never = v.never;
        hi_val    = v.hval;
        hi_reads  = v.hreads;
        lo_val    = v.lval;
        read_cnt  = 0;
        nlog      = 0;
        vcnt      = 0;
        stab_bad  = 0;
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rwn   = v.rwn;
        cmd_poll  = v.poll;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_mask  = v.mask;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"},   32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"},     rsp_rdata, v.exp_rdata);
        chk({tag, " err"},       32'(rsp_err), 32'(v.exp_err));
        chk({tag, " cfg_valid_in_resp"}, 32'(cfg_valid), 32'd0);
        chk({tag, " handshakes"}, 32'(nlog), 32'(v.exp_reads));
        chk({tag, " valid_cycles"}, 32'(vcnt), 32'(v.exp_vcyc));
        chk({tag, " stable"},    32'(stab_bad), 32'd0);
        if (nlog > 0) begin
            chk({tag, " cfg_rwn"},  32'(log_rwn[0]), 32'(v.rwn));
            chk({tag, " cfg_addr"}, 32'(log_addr[0]), 32'(v.addr));
            chk({tag, " cfg_data"}, log_data[0], v.rwn ? 32'd0 : v.wdata);
        end
        if (v.exp_gap > 0) begin
            for (int i = 1; i < nlog && i < 16; i++)
                chk($sformatf("%s poll_spacing%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'(v.exp_gap));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " back_to_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int acc0;
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_rwn = 1'b0; cmd_poll = 1'b0; cmd_addr = 5'd0;
        cmd_wdata = 32'd0; cmd_mask = 32'd0; rsp_ready = 1'b0;
        cmd2_valid = 1'b0; cmd2_rwn = 1'b0; cmd2_poll = 1'b0; cmd2_addr = 5'd0;
        cmd2_wdata = 32'd0; cmd2_mask = 32'd0; rsp2_ready = 1'b0;
        cfg_ready = 1'b0; cfg_data_in = 32'd0;

        //            rwn  poll addr   wdata          mask          dly nev hval           hrd lval           rdata          err rd lat vc gap
        vecs[0] = '{1'b0, 1'b0, 5'h00, 32'h0000_0100, 32'h0,         0, 0, 32'h0,          0,  32'h0,         32'h0,         1'b0, 1, 2, 1, 0};
        vecs[1] = '{1'b1, 1'b0, 5'h18, 32'h0,         32'h0,         3, 0, 32'h0000_0412, 100, 32'h0,         32'h0000_0412, 1'b0, 1, 5, 4, 0};
        vecs[2] = '{1'b1, 1'b1, 5'h18, 32'h0,         32'h0000_0400, 0, 0, 32'h0000_0412,  3,  32'h0000_0012, 32'h0000_0012, 1'b0, 4, 17, 4, 5};
        vecs[3] = '{1'b1, 1'b0, 5'h0C, 32'h0,         32'h0,         0, 1, 32'h1111_1111, 100, 32'h0,         32'h0,         1'b1, 0, 17, 16, 0};
        vecs[4] = '{1'b0, 1'b1, 5'h1F, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 32'h0,          0,  32'h0,         32'h0,         1'b0, 1, 2, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 5'h03, 32'h0000_005A, 32'h0000_00FF, 0, 0, 32'h1234_565A, 100, 32'h0,         32'h1234_565A, 1'b0, 1, 2, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 5'h11, 32'h0,         32'h0,        15, 0, 32'hCAFE_0001, 100, 32'h0,         32'hCAFE_0001, 1'b0, 1, 17, 16, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err",   32'(rsp_err), 32'd0);
        chk("rst cfg_valid", 32'(cfg_valid), 32'd0);
        chk("rst cfg_rwn",   32'(cfg_rwn), 32'd0);
        chk("rst cfg_addr",  32'(cfg_addr), 32'd0);
        chk("rst cfg_data",  cfg_data_out, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Response backpressure: held stable, no new command taken while pending
        @(negedge clk);
        slv_delay = 0; slv_never = 1'b0; hi_val = 32'h0000_0077; hi_reads = 100; read_cnt = 0;
        cmd_valid = 1'b1; cmd_rwn = 1'b1; cmd_poll = 1'b0; cmd_addr = 5'h07;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd2);
        acc0 = acc_cnt;
        cmd_valid = 1'b1; cmd_rwn = 1'b0; cmd_addr = 5'h09; cmd_wdata = 32'h55;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp rsp_valid%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp rdata%0d", k), rsp_rdata, 32'h0000_0077);
            chk($sformatf("bp cmd_ready%0d", k), 32'(cmd_ready), 32'd0);
        end
        chk("bp no_accept", 32'(acc_cnt - acc0), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp back_to_idle", 32'(cmd_ready), 32'd1);

        // Reset asserted while a read is stuck in ISSUE
        @(negedge clk);
        slv_never = 1'b1;
        cmd_valid = 1'b1; cmd_rwn = 1'b1; cmd_addr = 5'h05;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rst valid_before", 32'(cfg_valid), 32'd1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst cfg_valid", 32'(cfg_valid), 32'd0);
        chk("mid_rst cfg_addr",  32'(cfg_addr), 32'd0);
        chk("mid_rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        slv_never = 1'b0;
        run_vec(vecs[0], "post_rst");

        // Poll exhaustion on the MAX_POLLS=3, zero-gap instance
        @(negedge clk);
        n2 = 0;
        cmd2_valid = 1'b1; cmd2_rwn = 1'b1; cmd2_poll = 1'b1; cmd2_addr = 5'h02;
        cmd2_wdata = 32'h0; cmd2_mask = 32'hFF;
        @(negedge clk);
        cmd2_valid = 1'b0;
        lat = 1;
        while (!rsp2_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mp latency", 32'(lat), 32'd6);
        chk("mp rdata", rsp2_rdata, 32'h0000_00A5);
        chk("mp err", 32'(rsp2_err), 32'd1);
        chk("mp reads", 32'(n2), 32'd3);
        for (int i = 1; i < n2 && i < 16; i++)
            chk($sformatf("mp spacing%0d", i), 32'(log2_cyc[i] - log2_cyc[i-1]), 32'd2);
        rsp2_ready = 1'b1;
        @(negedge clk);
        rsp2_ready = 1'b0;
        chk("mp back_to_idle", 32'(cmd2_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
